// File: rtl/mac_dot_sequencer_if.sv
// Bundle between the dot-product job sequencer and its surroundings:
// host buffer-write/start port, the drive into the pipelined MAC, the
// MAC result return and the result valid/ready handshake.
// The sequencer uses the slave modport. The host/MAC side uses the master modport.
interface mac_dot_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int DEPTH      = 16
);
    logic                          wr_en;
    logic [$clog2(DEPTH)-1:0]      wr_addr;
    logic signed [DATA_WIDTH-1:0]  wr_a;
    logic signed [DATA_WIDTH-1:0]  wr_b;
    logic                          start;
    logic [$clog2(DEPTH):0]        len;
    logic                          busy;
    logic                          wr_err;
    logic signed [DATA_WIDTH-1:0]  mac_multiplier;
    logic signed [DATA_WIDTH-1:0]  mac_multiplicand;
    logic                          mac_valid;
    logic                          mac_clear;
    logic signed [ACC_WIDTH-1:0]   mac_result;
    logic signed [ACC_WIDTH-1:0]   res_data;
    logic                          res_valid;
    logic                          res_ready;
    logic [15:0]                   job_cnt;

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, len, mac_result, res_ready,
        output busy, wr_err, mac_multiplier, mac_multiplicand, mac_valid,
               mac_clear, res_data, res_valid, job_cnt
    );

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, len, mac_result, res_ready,
        input  busy, wr_err, mac_multiplier, mac_multiplicand, mac_valid,
               mac_clear, res_data, res_valid, job_cnt
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Dot-product job sequencer feeding the 2-register pipelined MAC.
// The host loads operand pairs into a local buffer. On start, the block issues one
// clear beat, then len operand beats, then one flush beat. It waits for
// the MAC pipeline to drain, captures mac_result and presents it on a
// valid/ready handshake.
// Optional build macro SEQ_JOB_COUNTER_EN adds a saturating count of
// completed jobs on job_cnt. Without the macro, job_cnt is tied to zero.
module mac_dot_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input logic                clk,
    input logic                reset,
    mac_dot_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_STREAM, S_FLUSH, S_DRAIN, S_RESP
    } state_t;

    state_t                       state_q, state_nxt;
    logic [LW-1:0]                len_q;
    logic [LW-1:0]                idx_q, idx_nxt;
    logic [DW-1:0]                drn_q, drn_nxt;
    logic [2*DATA_WIDTH-1:0]      mem [DEPTH];

    // next-cycle drive values (p0) and their registered copies on the outputs (p1)
    logic                         vld_p0, vld_p1;
    logic                         clr_p0, clr_p1;
    logic signed [DATA_WIDTH-1:0] op_a_p0, op_a_p1;
    logic signed [DATA_WIDTH-1:0] op_b_p0, op_b_p1;
    logic                         busy_p0, busy_p1;
    logic                         resv_p0, resv_p1;
    logic signed [ACC_WIDTH-1:0]  res_data_q;
    logic                         wr_err_q;

    logic accept;
    logic hs;

    // Job length never exceeds the buffer; larger requests stream the whole buffer.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
        return (l > LW'(DEPTH)) ? LW'(DEPTH) : l;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.start;
    assign hs     = resv_p1 && bus.res_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state logic, including the stream index and drain counter successors.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = '0;
        drn_nxt   = '0;
        case (state_q)
            S_IDLE:   if (bus.start) state_nxt = S_CLR;
            S_CLR:    state_nxt = (len_q != '0) ? S_STREAM : S_FLUSH;
            S_STREAM: begin
                if (idx_q == len_q - LW'(1)) state_nxt = S_FLUSH;
                else                         idx_nxt   = idx_q + LW'(1);
            end
            S_FLUSH:  state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (drn_q == DW'(DRAIN_CYCLES - 1)) state_nxt = S_RESP;
                else                                drn_nxt   = drn_q + DW'(1);
            end
            S_RESP:   if (hs) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a register.
    always_comb begin
        vld_p0  = 1'b0;
        clr_p0  = 1'b0;
        op_a_p0 = '0;
        op_b_p0 = '0;
        busy_p0 = (state_nxt != S_IDLE);
        resv_p0 = (state_nxt == S_RESP);
        case (state_nxt)
            S_CLR: begin
                vld_p0 = 1'b1;
                clr_p0 = 1'b1;
            end
            S_STREAM: begin
                vld_p0             = 1'b1;
                {op_a_p0, op_b_p0} = mem[idx_nxt[AW-1:0]];
            end
            S_FLUSH:  vld_p0 = 1'b1;
            default:  ;
        endcase
    end

    // ---- output register stage (p0 -> p1) ----
    // Registered outputs; reset drops the MAC drive immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            clr_p1  <= 1'b0;
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            busy_p1 <= 1'b0;
            resv_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            clr_p1  <= clr_p0;
            op_a_p1 <= op_a_p0;
            op_b_p1 <= op_b_p0;
            busy_p1 <= busy_p0;
            resv_p1 <= resv_p0;
        end
    end

    // Job control: latched length, stream index, drain count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            idx_q <= '0;
            drn_q <= '0;
        end else begin
            if (accept) len_q <= sat_len(bus.len);
            idx_q <= idx_nxt;
            drn_q <= drn_nxt;
        end
    end

    // Capture the MAC result on the last drain cycle and hold it through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          res_data_q <= '0;
        else if (state_q == S_DRAIN && state_nxt == S_RESP) res_data_q <= bus.mac_result;
    end

    // Sticky error for writes attempted while a job owns the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         wr_err_q <= 1'b0;
        else if (accept)                   wr_err_q <= 1'b0;
        else if (bus.wr_en && busy_p1)     wr_err_q <= 1'b1;
    end

    // Operand-pair buffer; no reset on the array.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_p1) mem[bus.wr_addr] <= {bus.wr_a, bus.wr_b};
    end

`ifdef SEQ_JOB_COUNTER_EN
    logic [15:0] job_cnt_q;

    // Saturating count of completed result handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          job_cnt_q <= '0;
        else if (hs && job_cnt_q != 16'hFFFF) job_cnt_q <= job_cnt_q + 16'd1;
    end

    assign bus.job_cnt = job_cnt_q;
`else
    assign bus.job_cnt = 16'h0000;
`endif

    assign bus.busy             = busy_p1;
    assign bus.wr_err           = wr_err_q;
    assign bus.mac_multiplier   = op_a_p1;
    assign bus.mac_multiplicand = op_b_p1;
    assign bus.mac_valid        = vld_p1;
    assign bus.mac_clear        = clr_p1;
    assign bus.res_data         = res_data_q;
    assign bus.res_valid        = resv_p1;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Testbench for mac_dot_sequencer: a behavioural MAC drives mac_result.
// A job-level reference model predicts every output cycle by cycle from
// the job start time, length and a shadow copy of the operand buffer.
module tb_mac_dot_sequencer;
    localparam int DATA_WIDTH   = 16;
    localparam int ACC_WIDTH    = 32;
    localparam int DEPTH        = 16;
    localparam int DRAIN_CYCLES = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_dot_sequencer_if #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) bus ();

    mac_dot_sequencer #(
        .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH),
        .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    int beats  = 0;
    int clrs   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural pipelined MAC: product register, accumulator, result register.
    logic signed [31:0] mac_prod = '0;
    logic signed [31:0] mac_acc  = '0;
    logic signed [31:0] mac_res  = '0;
    always @(posedge clk) begin
        if (bus.mac_valid) mac_prod <= bus.mac_multiplier * bus.mac_multiplicand;
        if (bus.mac_clear)      mac_acc <= '0;
        else if (bus.mac_valid) mac_acc <= mac_acc + mac_prod;
        mac_res <= mac_acc;
    end
    assign bus.mac_result = mac_res;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: job phase measured as cycles since acceptance.
    logic signed [15:0] sh_a [DEPTH];
    logic signed [15:0] sh_b [DEPTH];
    bit          m_busy = 1'b0, m_resv = 1'b0, m_wr_err = 1'b0;
    int          m_k = 0, m_len = 0;
    logic [31:0] m_res = '0;
    logic [15:0] m_jobs = '0;

    function automatic logic [31:0] dot(input int n);
        logic signed [31:0] s;
        s = 0;
        for (int i = 0; i < n; i++) s = s + sh_a[i] * sh_b[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_resv <= 1'b0; m_wr_err <= 1'b0;
            m_k <= 0; m_res <= '0; m_jobs <= '0;
        end else begin
            if (bus.wr_en) begin
                if (!m_busy) begin
                    sh_a[bus.wr_addr] <= bus.wr_a;
                    sh_b[bus.wr_addr] <= bus.wr_b;
                end else begin
                    m_wr_err <= 1'b1;
                end
            end
            if (!m_busy) begin
                if (bus.start) begin
                    m_busy   <= 1'b1;
                    m_k      <= 1;
                    m_len    <= (int'(bus.len) > DEPTH) ? DEPTH : int'(bus.len);
                    m_wr_err <= 1'b0;
                end
            end else if (m_resv) begin
                if (bus.res_ready) begin
                    m_resv <= 1'b0;
                    m_busy <= 1'b0;
                    if (m_jobs != 16'hFFFF) m_jobs <= m_jobs + 16'd1;
                end
            end else begin
                m_k <= m_k + 1;
                if (m_k + 1 == m_len + 3 + DRAIN_CYCLES) begin
                    m_resv <= 1'b1;
                    m_res  <= dot(m_len);
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    logic               ev;
    logic signed [15:0] ea, eb;
    always @(negedge clk) begin
        if (bus.mac_valid === 1'b1) beats++;
        if (bus.mac_clear === 1'b1) clrs++;
        if (check_en) begin
            if (reset) begin
                chk("rst_mac_valid", bus.mac_valid, 1'b0);
                chk("rst_mac_clear", bus.mac_clear, 1'b0);
                chk("rst_mac_a", bus.mac_multiplier, '0);
                chk("rst_mac_b", bus.mac_multiplicand, '0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_wr_err", bus.wr_err, 1'b0);
                chk("rst_res_valid", bus.res_valid, 1'b0);
                chk("rst_res_data", bus.res_data, '0);
                chk("rst_job_cnt", bus.job_cnt, '0);
            end else begin
                ev = m_busy && !m_resv && (m_k >= 1) && (m_k <= m_len + 2);
                chk("mac_valid", bus.mac_valid, ev);
                chk("mac_clear", bus.mac_clear, ev && (m_k == 1));
                if (ev) begin
                    ea = '0;
                    eb = '0;
                    if (m_k >= 2 && m_k <= m_len + 1) begin
                        ea = sh_a[m_k-2];
                        eb = sh_b[m_k-2];
                    end
                    chk("mac_multiplier", bus.mac_multiplier, ea);
                    chk("mac_multiplicand", bus.mac_multiplicand, eb);
                end
                chk("res_valid", bus.res_valid, m_resv);
                if (m_resv) chk("res_data", bus.res_data, m_res);
                chk("busy", bus.busy, m_busy);
                chk("wr_err", bus.wr_err, m_wr_err);
`ifdef SEQ_JOB_COUNTER_EN
                chk("job_cnt", bus.job_cnt, m_jobs);
`else
                chk("job_cnt", bus.job_cnt, '0);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int a, input int b);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_a    = 16'(a);
        bus.wr_b    = 16'(b);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // One cycle with optional stray writes/starts that the DUT must ignore while busy.
    task automatic noise_tick(input bit noise);
        if (noise && $urandom_range(0, 3) == 0) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'($urandom_range(0, 15));
            bus.wr_a    = 16'($urandom);
            bus.wr_b    = 16'($urandom);
        end
        if (noise && $urandom_range(0, 5) == 0) bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
    endtask

    // t0 is the cycle in which start was sampled (cycle T).
    task automatic start_job(input int len);
        bus.start = 1'b1;
        bus.len   = 5'(len);
        tick();
        bus.start = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic finish_job(input int stall, input bit noise, input bit hs_start,
                              output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (bus.res_valid !== 1'b1 && guard < 200) begin
            noise_tick(noise);
            guard++;
        end
        chk("res_valid_timeout", bus.res_valid, 1'b1);
        lat = cyc - t0;
        for (int i = 0; i < stall; i++) noise_tick(noise);
        res           = bus.res_data;
        bus.res_ready = 1'b1;
        bus.start     = hs_start;
        tick();
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        if (hs_start) chk("start_at_handshake_ignored", bus.busy, 1'b0);
    endtask

    logic [31:0] res;
    int          lat;

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_a = '0; bus.wr_b = '0;
        bus.start = 1'b0; bus.len = '0; bus.res_ready = 1'b0;
        #2;
        reset    = 1'b1;
        check_en = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_state_busy", bus.busy, 1'b0);
        chk("reset_state_res_valid", bus.res_valid, 1'b0);

        for (int i = 0; i < DEPTH; i++) wr(i, $urandom, $urandom);

        // (1,2),(3,4),(5,6): 2+12+30 = 44, result at T+8, five MAC beats
        wr(0, 1, 2); wr(1, 3, 4); wr(2, 5, 6);
        beats = 0; clrs = 0;
        start_job(3);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("job44_res", res, 32'd44);
        chk("job44_latency", lat, 8);
        chk("job44_beats", beats, 5);
        chk("job44_clears", clrs, 1);
        chk("job44_busy_after", bus.busy, 1'b0);

        // len=0 with the accumulator still holding 44: clear + flush only
        beats = 0;
        start_job(0);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("len0_res", res, 32'd0);
        chk("len0_beats", beats, 2);
        chk("len0_latency", lat, 5);

        // (-3)*7 + 2*(-5) = -31
        wr(0, -3, 7); wr(1, 2, -5);
        start_job(2);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("neg_res", res, 32'hFFFFFFE1);

        // Consumer stalls 10 cycles; stray starts ignored, start at handshake ignored
        wr(0, 1, 1); wr(1, 2, 2);
        start_job(2);
        finish_job(10, 1'b1, 1'b1, res, lat);
        chk("stall_res", res, 32'd5);
        start_job(2);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("after_stall_latency", lat, 7);
        chk("after_stall_res", res, 32'd5);

        // Write during STREAM is dropped and flags wr_err until next accepted start
        wr(0, 1, 2); wr(1, 3, 4); wr(2, 5, 6);
        start_job(3);
        tick();
        wr(1, 100, 100);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("drop_res", res, 32'd44);
        chk("drop_wr_err_set", bus.wr_err, 1'b1);
        start_job(3);
        chk("drop_wr_err_cleared", bus.wr_err, 1'b0);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("drop_old_value_res", res, 32'd44);

        // Reset in the middle of a len=8 stream
        for (int i = 0; i < 8; i++) wr(i, $urandom, $urandom);
        start_job(8);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("midrst_mac_valid", bus.mac_valid, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        wr(0, 4, 4);
        start_job(1);
        finish_job(0, 1'b0, 1'b0, res, lat);
        chk("post_reset_res", res, 32'd16);
`ifdef SEQ_JOB_COUNTER_EN
        chk("post_reset_job_cnt", bus.job_cnt, 32'd1);
`endif

        // Randomized jobs including over-length requests and stray traffic
        repeat (25) begin
            repeat ($urandom_range(0, 4))
                wr($urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 65535));
            start_job($urandom_range(0, 31));
            finish_job($urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), res, lat);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Job sequencer directly upstream of the team's pipelined MAC unit. Holds an operand-pair buffer loaded by the host and, on start, streams the pairs into the MAC with valid/clear timing matched to its 2-register pipeline. After the pipeline drains it captures the MAC result and returns it over a valid/ready handshake. The result is one dot product per job.

Parameters:
DATA_WIDTH, 16, operand width; signed; must match the MAC.
ACC_WIDTH, 32, MAC result width.
DEPTH, 16, operand-pair buffer entries; power of 2, at least 2.
DRAIN_CYCLES, 2, cycles to wait after the flush beat before sampling mac_result; at least 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
wr_en  in  1  buffer write strobe
wr_addr  in  $clog2(DEPTH)  buffer write address
wr_a  in  DATA_WIDTH  multiplier operand to store
wr_b  in  DATA_WIDTH  multiplicand operand to store
start  in  1  job start request
len  in  $clog2(DEPTH)+1  number of pairs in the job; sampled when start is accepted
busy  out  1  high from start acceptance until the result handshake completes
wr_err  out  1  sticky: a write arrived while busy; cleared on start acceptance
mac_multiplier  out  DATA_WIDTH  to MAC multiplier
mac_multiplicand  out  DATA_WIDTH  to MAC multiplicand
mac_valid  out  1  to MAC valid
mac_clear  out  1  to MAC clear
mac_result  in  ACC_WIDTH  from MAC result
res_data  out  ACC_WIDTH  captured dot product
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
job_cnt  out  16  completed-job counter; see Optional Feature

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0. Buffer contents are undefined, with no reset on the array.
- Downstream contract:
  - MAC product register loads on valid.
  - MAC accumulator adds the previous product on valid; clear has priority over valid.
  - MAC result is the accumulator registered one cycle later.
  - A zero operand pair yields a zero product.
- Buffer writes:
  - Accepted only when busy=0: mem[wr_addr] <= {wr_a, wr_b}.
  - wr_en while busy=1 is dropped and sets wr_err.
- start:
  - Accepted only in IDLE. Ignored in all other states.
  - On acceptance: latch len, saturated to DEPTH; clear wr_err; busy=1.
- FSM, all outputs registered:
  - IDLE: mac_valid=0, mac_clear=0. On start go to CLR.
  - CLR (1 cycle): mac_clear=1, mac_valid=1, operands=0, which zeroes both the accumulator and the product. Next state is STREAM if len>0, else FLUSH.
  - STREAM (len cycles): mac_valid=1, operands=mem[idx], idx counts 0..len-1. Go to FLUSH after idx=len-1.
  - FLUSH (1 cycle): mac_valid=1, operands=0, which accumulates the last product.
  - DRAIN: mac_valid=0. Count DRAIN_CYCLES, then res_data <= mac_result, res_valid=1, go to RESP.
  - RESP: hold res_data/res_valid stable until res_ready. On res_valid&&res_ready: res_valid=0, busy=0, job_cnt++, go to IDLE.
- Latency: start accepted at cycle T. res_valid rises at T+1+1+len+1+DRAIN_CYCLES, i.e. T+len+5 with defaults.
- start sampled in the same cycle as the RESP handshake is ignored; a new start is accepted from the next cycle.
- len=0: result is 0.
- len>DEPTH: clamped to DEPTH.
- Operands are streamed unmodified: no internal arithmetic, no sign extension.
- Reset mid-job: immediate return to IDLE. mac_valid and mac_clear drop asynchronously. Partial MAC state is abandoned; the next job's CLR cleans it.

Optional Feature:
SEQ_JOB_COUNTER_EN
- Defined: job_cnt increments on each completed result handshake, saturating at 16'hFFFF, reset to 0.
- Undefined: job_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- Write pairs (1,2),(3,4),(5,6) to addr 0..2; start with len=3; res_ready=1 -> mac_valid high for 5 cycles, mac_clear only in the first, res_data=44 at T+8, busy low after the handshake.
- Pairs (-3,7),(2,-5); len=2 -> res_data=-31 (0xFFFFFFE1).
- len=0 after a prior job left the accumulator at 44 -> res_data=0; exactly 2 mac_valid beats (CLR, FLUSH).
- res_ready held low for 10 cycles after res_valid -> res_data stable, busy=1, second start ignored; after the handshake the next start is accepted.
- wr_en during STREAM to addr 1 -> write dropped (next job reads the old value), wr_err=1 until the next accepted start.
- Assert reset during STREAM of a len=8 job -> all outputs 0 immediately; a following len=1 job (4,4) returns 16. With SEQ_JOB_COUNTER_EN, job_cnt=1 after that job.
